// File: rtl/tour_cmd_seq_if.sv
// tour_cmd_seq_if: solver, UART and command-processor signals of the tour command sequencer
interface tour_cmd_seq_if;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic [7:0]  resp;
   logic        tour_err;
   modport master (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, cmd, cmd_rdy, resp, tour_err
   );
   modport slave (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, cmd, cmd_rdy, resp, tour_err
   );
endinterface

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: splits each knight's-tour move into vertical/horizontal commands; UART pass-through when idle.
// Build option TOUR_FANFARE_EN: horizontal leg uses the fanfare opcode instead of the plain move opcode.
module tour_cmd_seq #(
   parameter int          NUM_MOVES   = 24,
   parameter logic [3:0]  OPC_MOVE    = 4'h2,
   parameter logic [3:0]  OPC_FANFARE = 4'h3
) (
   input logic            clk,
   input logic            rst_n,
   tour_cmd_seq_if.master bus
);
`ifdef TOUR_FANFARE_EN
   localparam logic FANFARE = 1'b1;
`else
   localparam logic FANFARE = 1'b0;
`endif
   localparam logic [3:0] HORZ_OPC = FANFARE ? OPC_FANFARE : OPC_MOVE;
   typedef enum logic [2:0] {IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT} state_t;
   state_t      state, nxt_state;
   logic [4:0]  indx, nxt_indx;
   logic        legal, last, up, dy2, right, dx2;
   logic [15:0] vert_cmd, horz_cmd;
   // move decode: bits with dy>0 are b0,b1,b2,b7; |dy|=2 on b0,b1,b4,b5; dx>0 on b0,b5,b6,b7; |dx|=2 on b2,b3,b6,b7
   always_comb begin
      legal    = $onehot(bus.move);
      up       = |(bus.move & 8'b1000_0111);
      dy2      = |(bus.move & 8'b0011_0011);
      right    = |(bus.move & 8'b1110_0001);
      dx2      = |(bus.move & 8'b1100_1100);
      vert_cmd = {OPC_MOVE, up ? 8'h00 : 8'h7F, dy2 ? 4'd2 : 4'd1};
      horz_cmd = {HORZ_OPC, right ? 8'hBF : 8'h3F, dx2 ? 4'd2 : 4'd1};
      last     = indx == 5'(NUM_MOVES - 1);
   end
   // next-state, index update and command/handshake outputs
   always_comb begin
      nxt_state   = state;
      nxt_indx    = indx;
      bus.cmd     = bus.cmd_UART;
      bus.cmd_rdy = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_rdy = bus.cmd_rdy_UART;
            if (bus.start_tour) begin
               nxt_state = VERT;
               nxt_indx  = 5'd0;
            end
         end
         VERT: begin
            bus.cmd     = vert_cmd;
            bus.cmd_rdy = legal;
            if (!legal) begin
               nxt_state = IDLE;
               nxt_indx  = 5'd0;
            end else if (bus.clr_cmd_rdy)
               nxt_state = VERT_WAIT;
         end
         VERT_WAIT: begin
            bus.cmd = vert_cmd;
            if (bus.send_resp) nxt_state = HORZ;
         end
         HORZ: begin
            bus.cmd     = horz_cmd;
            bus.cmd_rdy = 1'b1;
            if (bus.clr_cmd_rdy) nxt_state = HORZ_WAIT;
         end
         HORZ_WAIT: begin
            bus.cmd = horz_cmd;
            if (bus.send_resp) begin
               nxt_state = last ? IDLE : VERT;
               nxt_indx  = last ? 5'd0 : indx + 5'd1;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_indx  = 5'd0;
         end
      endcase
   end
   // state, move index and error pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         indx         <= 5'd0;
         bus.tour_err <= 1'b0;
      end else begin
         state        <= nxt_state;
         indx         <= nxt_indx;
         bus.tour_err <= (state == VERT) && !legal;
      end
   end
   assign bus.mv_indx = indx;
   assign bus.resp    = (state != IDLE && !last) ? 8'hA5 : 8'h5A;
endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sits directly downstream of the knight's-tour solver and upstream of the command processor.
- After the solver signals completion, it walks the stored move list by index.
- Each one-hot knight move is split into a vertical leg followed by a horizontal leg, and each leg is issued as a 16-bit movement command with a ready/clear/response handshake.
- Outside a tour, UART-sourced commands pass straight through to the command processor.

Parameters:
- NUM_MOVES, 24: number of moves in a tour; indices 0..NUM_MOVES-1.
- OPC_MOVE, 4'h2: opcode for a plain move command.
- OPC_FANFARE, 4'h3: opcode for move-with-fanfare.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start_tour  in  1  one-cycle pulse from the solver's done
- move  in  8  one-hot move for the current mv_indx
- mv_indx  out  5  index presented to the solver move store
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy  in  1  command processor has taken the command
- send_resp  in  1  command processor has finished executing the command
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  command valid
- resp  out  8  response byte to the UART
- tour_err  out  1  one-cycle pulse: illegal move encoding

Behaviour:
- Reset values: state IDLE, mv_indx 0, tour_err 0.
- Move decode. Bit i selects (dx,dy):
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
- Vertical leg: heading 8'h00 if dy>0, 8'h7F if dy<0; squares = |dy|.
- Horizontal leg: heading 8'hBF if dx>0, 8'h3F if dx<0; squares = |dx|.
- Command format: {opcode[3:0], heading[7:0], squares[3:0]}. The vertical leg always uses OPC_MOVE.
- FSM states: IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- IDLE:
  - cmd = cmd_UART and cmd_rdy = cmd_rdy_UART (combinational pass-through).
  - start_tour → VERT with mv_indx = 0.
- VERT: cmd = vertical command, cmd_rdy = 1. On clr_cmd_rdy → VERT_WAIT.
- VERT_WAIT: cmd held, cmd_rdy = 0. On send_resp → HORZ.
- HORZ: cmd = horizontal command, cmd_rdy = 1. On clr_cmd_rdy → HORZ_WAIT.
- HORZ_WAIT: cmd held, cmd_rdy = 0. On send_resp:
  - if mv_indx == NUM_MOVES-1 → IDLE, mv_indx cleared to 0;
  - else mv_indx increments and → VERT.
- Latency: cmd_rdy rises the cycle after start_tour is sampled.
- send_resp is ignored in VERT and HORZ; clr_cmd_rdy is ignored in the WAIT states.
- If clr_cmd_rdy and send_resp are high together in VERT or HORZ, only the clear is acted on.
- start_tour outside IDLE is ignored; cmd_rdy_UART is ignored outside IDLE.
- Illegal move (zero or more than one bit set) in VERT:
  - tour_err pulses for one cycle;
  - FSM → IDLE, mv_indx → 0;
  - no command is issued.
- resp = 8'hA5 while in tour states with mv_indx < NUM_MOVES-1; otherwise 8'h5A.
- move is sampled combinationally from mv_indx; mv_indx is stable for the whole two-leg sequence.
- Reset asserted mid-tour aborts immediately to IDLE and mv_indx 0; cmd_rdy follows cmd_rdy_UART.

Optional Feature:
- Macro TOUR_FANFARE_EN.
- Defined: the horizontal leg uses OPC_FANFARE (e.g. 16'h3BF1).
- Undefined: the horizontal leg uses OPC_MOVE (e.g. 16'h2BF1). All other behaviour is identical.

Test Plan:
- Pass-through: IDLE, cmd_UART=16'h1234, cmd_rdy_UART=1 → cmd=16'h1234, cmd_rdy=1, resp=8'h5A.
- Single move: start_tour, move=8'h01 → cmd=16'h2002 with cmd_rdy. After clr_cmd_rdy then send_resp → cmd=16'h3BF1 (fanfare on) or 16'h2BF1 (off); resp=8'hA5.
- Move 8'h08 → vertical 16'h27F1, horizontal 16'h33F2/16'h23F2. Holding clr_cmd_rdy and send_resp high together in VERT yields VERT_WAIT only.
- Full tour: 24 moves with correct handshakes → mv_indx steps 0..23, 48 commands issued, final resp=8'h5A, return to IDLE with mv_indx=0.
- Illegal move: move=8'h00 or 8'h03 at index 5 → tour_err pulses once, no cmd_rdy, IDLE, mv_indx=0.
- rst_n low during HORZ_WAIT at mv_indx=10 → IDLE, mv_indx=0; a subsequent start_tour restarts from index 0.
